rb_fifo_param: RTL

//  Parametrised ring-buffer FIFO: successor to the fixed 4-entry rbFIFO.

---
 rtl/rb_fifo_pkg.sv | 16 +
 rtl/rb_fifo_ptr.sv | 31 +++
 rtl/rb_fifo_param.sv | 101 ++++++++++
 3 files changed

// File: rtl/rb_fifo_pkg.sv
// Shared types and the wrap-increment helper for the ring-buffer FIFO.
package rb_fifo_pkg;

    localparam int PTR_WIDE_W = 32;

    // Wide carriers so the helper works for any pointer width; callers narrow the result.
    typedef logic [PTR_WIDE_W-1:0] ptr_wide_t;
    typedef logic [PTR_WIDE_W:0]   cnt_wide_t;

    // Advance a ring pointer; wraps from depth-1 to 0 by explicit compare so
    // non-power-of-two depths never visit unused slots.
    function automatic ptr_wide_t ptr_next(input ptr_wide_t ptr, input ptr_wide_t depth);
        return (ptr == depth - ptr_wide_t'(1)) ? '0 : ptr + ptr_wide_t'(1);
    endfunction

endpackage

// File: rtl/rb_fifo_ptr.sv
// Wrapping pointer register, used for both head and tail of the ring buffer.
module rb_fifo_ptr
    import rb_fifo_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          inc,
    output logic [AW-1:0] ptr_o
);

    logic [AW-1:0] ptr_q, ptr_d;

    // Next pointer: hold, or step with wrap at DEPTH-1.
    always_comb begin
        ptr_d = ptr_q;
        if (inc)
            ptr_d = AW'(ptr_next(ptr_wide_t'(ptr_q), ptr_wide_t'(DEPTH)));
    end

    // Pointer register, cleared immediately on reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/rb_fifo_param.sv
// Parametrised ring-buffer FIFO with first-word fall-through output,
// occupancy count, threshold flags and sticky overflow/underflow errors.
module rb_fifo_param
    import rb_fifo_pkg::*;
#(
    parameter int DW     = 8,
    parameter int DEPTH  = 4,
    parameter int AW     = $clog2(DEPTH),
    parameter int AF_LVL = DEPTH - 1,
    parameter int AE_LVL = 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [DW-1:0] dataIn,
    input  logic          push,
    input  logic          pop,
    input  logic          clr_err,
    output logic [DW-1:0] dataOut,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          underflow
);

    localparam logic [AW:0] CNT_ONE   = (AW+1)'(1);
    localparam logic [AW:0] CNT_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_AF    = (AW+1)'(AF_LVL);
    localparam logic [AW:0] CNT_AE    = (AW+1)'(AE_LVL);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] head, tail;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          push_ok, pop_ok;

    // A push on a full FIFO still goes through when a pop frees the head slot
    // in the same cycle; a pop on an empty FIFO never does.
    assign push_ok = push & (~full | pop);
    assign pop_ok  = pop & ~empty;

    rb_fifo_ptr #(.DEPTH(DEPTH), .AW(AW)) u_head (
        .clock (clock),
        .reset (reset),
        .inc   (pop_ok),
        .ptr_o (head)
    );

    rb_fifo_ptr #(.DEPTH(DEPTH), .AW(AW)) u_tail (
        .clock (clock),
        .reset (reset),
        .inc   (push_ok),
        .ptr_o (tail)
    );

    // Storage write; contents are deliberately not reset, count gates visibility.
    always_ff @(posedge clock) begin
        if (push_ok) mem_q[tail] <= dataIn;
    end

    // Occupancy and sticky error next-state; a fresh error beats clr_err.
    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        overflow_d  = clr_err ? 1'b0 : overflow_q;
        underflow_d = clr_err ? 1'b0 : underflow_q;
        if (push & full & ~pop) overflow_d  = 1'b1;
        if (pop & empty)        underflow_d = 1'b1;
    end

    // Count and error flag registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign dataOut      = mem_q[head];
    assign count        = count_q;
    assign full         = (count_q == CNT_DEPTH);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CNT_AF);
    assign almost_empty = (count_q <= CNT_AE);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule
